// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// controller state encoding and the default data-memory watchdog limit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_e;

    localparam int DEFAULT_MEM_TIMEOUT = 16;

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating performance counter: counts cycles with inc=1 and sticks at
// all-ones. Synchronous active-high reset clears it.
module pipe_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear on reset, otherwise increment unless already saturated
    always_comb begin
        count_d = count_q;
        if (reset) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Drives hold-enables
// and bubble-flush strobes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
// Priority: data-memory wait > taken branch in MEM > load-use hazard.
// A watchdog moves to a sticky error state if data memory never answers.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined;
// otherwise stall_cycles and flush_count read as zero.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             mem_req,
    input  logic             dmem_ready,
    input  logic             mem_branch_taken,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int             WD_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            mem_err_q, mem_err_d;

    logic lu_hazard;
    logic mem_stall;
    logic active;

    // A dropped mem_req during the wait counts as a completed access
    assign mem_stall = mem_req & ~dmem_ready;
    assign lu_hazard = ex_memread && (ex_rd != 5'd0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));
    // RUN and MEM_WAIT share the same priority rules; MEM_WAIT simply keeps
    // hitting the memory-stall rule until the access completes.
    assign active = ~reset & ((state_q == RUN) | (state_q == MEM_WAIT));

    // Enable/flush outputs from state and current hazards, highest priority first
    always_comb begin
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (active) begin
            if (mem_stall) begin
                // Freeze everything up to MEM; let WB drain with a bubble
                mem_wb_en    = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (mem_branch_taken) begin
                // PC takes the target; squash the three younger instructions
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (lu_hazard) begin
                // Hold PC and IF/ID for one cycle, inject a bubble into EX
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
            end
        end
    end

    // Next state, watchdog and sticky error
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        mem_err_d = mem_err_q;
        if (reset) begin
            state_d   = RUN;
            wd_d      = '0;
            mem_err_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_stall) begin
                        state_d = MEM_WAIT;
                        wd_d    = WD_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (!mem_stall) begin
                        // A response on the limit cycle is still accepted
                        state_d = RUN;
                        wd_d    = '0;
                    end else if (wd_q >= WD_MAX) begin
                        state_d   = ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        wd_d = wd_q + WD_W'(1);
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = RUN;
                    wd_d    = '0;
                end
            endcase
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        wd_q      <= wd_d;
        mem_err_q <= mem_err_d;
    end

    assign state   = state_q;
    assign mem_err = mem_err_q;

`ifdef PIPE_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = ~reset & ~pc_en;
    assign flush_inc = active & ~mem_stall & mem_branch_taken;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .count (flush_count)
    );
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4). Each directed
// cycle pushes its hand-computed expectation; a negedge monitor pops and
// compares against the DUT outputs for that cycle.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_memread;
    logic             mem_req, dmem_ready, mem_branch_taken;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0]       state;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .ex_rd            (ex_rd),
        .ex_memread       (ex_memread),
        .mem_req          (mem_req),
        .dmem_ready       (dmem_ready),
        .mem_branch_taken (mem_branch_taken),
        .pc_en            (pc_en),
        .if_id_en         (if_id_en),
        .id_ex_en         (id_ex_en),
        .ex_mem_en        (ex_mem_en),
        .mem_wb_en        (mem_wb_en),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .ex_mem_flush     (ex_mem_flush),
        .mem_wb_flush     (mem_wb_flush),
        .state            (state),
        .mem_err          (mem_err),
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    // en  = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem, mem_wb}
    localparam logic [4:0] E_ALL = 5'b11111, E_MS = 5'b00001, E_LU = 5'b00111, E_NO = 5'b00000;
    localparam logic [3:0] F_NO = 4'b0000, F_MS = 4'b0001, F_BR = 4'b1110, F_LU = 4'b0100;
    localparam logic [1:0] S_RUN = 2'd0, S_MW = 2'd1, S_ERR = 2'd2;

    typedef struct packed {
        logic [4:0]  en;
        logic [3:0]  fl;
        logic [1:0]  st;
        logic        err;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req, input int cyc);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set
    int mon_cyc = 0;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp("en",      {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e.en}, mon_cyc);
            cmp("flush",   {28'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {28'd0, e.fl}, mon_cyc);
            cmp("state",   {30'd0, state}, {30'd0, e.st}, mon_cyc);
            cmp("mem_err", {31'd0, mem_err}, {31'd0, e.err}, mon_cyc);
            cmp("stall_cycles", stall_cycles, e.sc, mon_cyc);
            cmp("flush_count",  flush_count,  e.fc, mon_cyc);
            mon_cyc++;
        end
    end

    // Drive one cycle of inputs, push its expectation, advance past the edge
    task automatic step(input logic r, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic ld,
                        input logic mreq, input logic rdy, input logic br,
                        input logic [4:0] e_en, input logic [3:0] e_fl,
                        input logic [1:0] e_st, input logic e_err,
                        input int e_sc, input int e_fc);
        exp_t e;
        reset = r; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        ex_rd = rd; ex_memread = ld; mem_req = mreq; dmem_ready = rdy; mem_branch_taken = br;
        e.en = e_en; e.fl = e_fl; e.st = e_st; e.err = e_err;
`ifdef PIPE_CTRL_PERF_EN
        e.sc = 32'(e_sc); e.fc = 32'(e_fc);
`else
        e.sc = 32'd0; e.fc = 32'd0;
`endif
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Unchecked first reset cycle to bring state out of X
        reset = 1'b1; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_rd = 0; ex_memread = 0; mem_req = 0; dmem_ready = 0; mem_branch_taken = 0;
        @(posedge clk);
        #1;
        //     r  rs1 u1 rs2 u2 rd ld mq rd br   en     fl    st     err sc  fc
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_NO,  F_NO, S_RUN, 0,  0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  0, 0);
        // load-use via rs2: one bubble, then free-running
        step(0, 0, 0, 5, 1, 5, 1, 0, 0, 0,  E_LU,  F_LU, S_RUN, 0,  0, 0);
        step(0, 0, 0, 5, 1, 3, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  1, 0);
        // load to x0 never stalls
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  1, 0);
        // matching rs1 that the ID instruction does not read
        step(0, 7, 0, 0, 0, 7, 1, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  1, 0);
        // memory stall for three cycles, ready on the fourth
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_RUN, 0,  1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0,  2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0,  3, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  E_ALL, F_NO, S_MW,  0,  4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  4, 0);
        // branch coincident with load-use: flush, no stall
        step(0, 3, 1, 0, 0, 3, 1, 0, 0, 1,  E_ALL, F_BR, S_RUN, 0,  4, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  4, 1);
        // branch held behind a memory stall, taken when ready
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  E_MS,  F_MS, S_RUN, 0,  4, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 1,  E_MS,  F_MS, S_MW,  0,  5, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1,  E_ALL, F_BR, S_MW,  0,  6, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  6, 2);
        // mem_req dropped in MEM_WAIT acts as ready; load-use resolved that cycle
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_RUN, 0,  6, 2);
        step(0, 0, 0, 9, 1, 9, 1, 0, 0, 0,  E_LU,  F_LU, S_MW,  0,  7, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  8, 2);
        // response on the watchdog-limit cycle is accepted
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_RUN, 0,  8, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0,  9, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0, 10, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0, 11, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  E_ALL, F_NO, S_MW,  0, 12, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0, 12, 2);
        // no response: four MEM_WAIT cycles, then sticky ERR
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_RUN, 0, 12, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0, 13, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0, 14, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0, 15, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0, 16, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  E_NO,  F_NO, S_ERR, 1, 17, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  E_NO,  F_NO, S_ERR, 1, 18, 2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_NO,  F_NO, S_ERR, 1, 19, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  0, 0);
        // reset in the middle of a memory wait
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_RUN, 0,  0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_MW,  0,  1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_NO,  F_NO, S_MW,  0,  2, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  E_MS,  F_MS, S_RUN, 0,  0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  E_ALL, F_NO, S_MW,  0,  1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  E_ALL, F_NO, S_RUN, 0,  1, 0);

        // Let the monitor drain, bounded
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
